sequence_pattern_generator: RTL

- Serial bit-stream source for the Mealy sequence detector.
- Accepts a parallel word through a valid/ready handshake and shifts it out LSB-first, one bit per clock, on `out`.
- Supports programmable length, seamless repeat, back-to-back loads and abort.
- Drives the detector's `in` port in system and bench setups.

---
 rtl/sequence_pattern_generator.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sequence_pattern_generator.sv
// Serial LSB-first bit-stream source with valid/ready load, programmable length, repeat and abort.
// Optional trailing even-parity bit when SEQGEN_PARITY_EN is defined.
module sequence_pattern_generator #(
    parameter int unsigned WIDTH    = 20,
    parameter int unsigned CNT_W    = 5,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] load_len,
    input  logic             repeat_en,
    input  logic             stop,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

`ifdef SEQGEN_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SEQGEN_PARITY_EN
    logic             par_q, par_d;
`endif

    logic [CNT_W-1:0] eff_len;
    logic [WIDTH-1:0] src_word;
    logic [CNT_W-1:0] src_len;
    logic             bit_end;
    logic             last_bit;
    logic             accept;
    logic             reload;

    assign eff_len = (load_len == '0 || load_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : load_len;

    // bit_end marks the final data bit; last_bit is the cycle where the word truly completes
    assign bit_end = (state_q == StShift) && (cnt_q == CNT_W'(1));
`ifdef SEQGEN_PARITY_EN
    assign last_bit = (state_q == StParity);
`else
    assign last_bit = bit_end;
`endif

    assign load_ready = !reset && !stop && ((state_q == StIdle) || (last_bit && !repeat_en));
    assign accept     = load_valid && load_ready;
    assign reload     = !stop && last_bit && repeat_en;
    assign src_word   = accept ? load_data : hold_q;
    assign src_len    = accept ? eff_len : len_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            shift_q <= '0;
            hold_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            out_q   <= IDLE_BIT;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQGEN_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SEQGEN_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) state_d = StShift;
                end
                StShift: begin
                    if (bit_end) begin
`ifdef SEQGEN_PARITY_EN
                        state_d = StParity;
`else
                        state_d = (reload || accept) ? StShift : StIdle;
`endif
                    end
                end
`ifdef SEQGEN_PARITY_EN
                StParity: begin
                    state_d = (reload || accept) ? StShift : StIdle;
                end
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        shift_d = shift_q;
        hold_d  = hold_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        out_d   = IDLE_BIT;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SEQGEN_PARITY_EN
        par_d   = par_q;
`endif
        if (!stop) begin
            if (accept || reload) begin
                hold_d  = src_word;
                len_d   = src_len;
                out_d   = src_word[0];
                shift_d = src_word >> 1;
                cnt_d   = src_len;
                valid_d = 1'b1;
                busy_d  = 1'b1;
`ifdef SEQGEN_PARITY_EN
                par_d   = src_word[0];
`else
                done_d  = (src_len == CNT_W'(1));
`endif
            end else if (state_q == StShift && !bit_end) begin
                out_d   = shift_q[0];
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q - CNT_W'(1);
                valid_d = 1'b1;
                busy_d  = 1'b1;
`ifdef SEQGEN_PARITY_EN
                par_d   = par_q ^ shift_q[0];
`else
                done_d  = (cnt_q == CNT_W'(2));
`endif
            end
`ifdef SEQGEN_PARITY_EN
            else if (bit_end) begin
                out_d   = par_q;
                valid_d = 1'b1;
                busy_d  = 1'b1;
                done_d  = 1'b1;
            end
`endif
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
